// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the byte-wide RAM port between fetch, load and store drain.
// Grants are serialised into byte beats; read bytes are assembled little-endian.
module ram_port_arbiter #(
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic [7:0]  ram_data_i,
    output logic [7:0]  ram_data_o,
    output logic [31:0] ram_addr,
    output logic        ram_rw_sel,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_len,
    output logic        ld_done,
    output logic [31:0] ld_data,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [2:0]  st_len,
    input  logic [31:0] st_data,
    output logic        st_done
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t        state;
    logic          owner_if;
    logic [2:0]    cnt;
    logic [2:0]    len_q;
    logic [31:0]   base_q;
    logic [31:0]   wbuf_q;
    logic [31:0]   rbuf_q;
    logic [SW-1:0] starve;
    logic          rw_q;

    logic          any_done;
    logic          arb_ok;
    logic          starve_hit;
    logic          grant_st;
    logic          grant_ld;
    logic          grant_if;
    logic [2:0]    last;
    logic [2:0]    nxt;
    logic [2:0]    off;
    logic [4:0]    lo;
    logic [31:0]   rbuf_nx;

    // The write strobe never escapes while the whole system is frozen
    assign ram_rw_sel = rw_q & rdy;

    // Arbitration decision and per-beat address/byte-lane bookkeeping
    always_comb begin
        any_done   = if_done | ld_done | st_done;
        arb_ok     = (state == IDLE) && !any_done;
        starve_hit = (starve == SW'(STARVE_LIMIT)) && if_req && !flush;
        grant_st   = arb_ok && !starve_hit && st_req;
        grant_ld   = arb_ok && !starve_hit && !st_req && ld_req && !flush;
        grant_if   = arb_ok && (starve_hit ||
                     (!st_req && !ld_req && if_req && !flush));
        last       = len_q - 3'd1;
        nxt        = cnt + 3'd1;
        off        = (nxt > last) ? last : nxt;
        lo         = {cnt[1:0] - 2'd1, 3'b000};
        rbuf_nx    = rbuf_q;
        rbuf_nx[lo +: 8] = ram_data_i;
    end

    // Port FSM: grant, byte beats, data assembly and done pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_if   <= 1'b0;
            cnt        <= '0;
            len_q      <= '0;
            base_q     <= '0;
            wbuf_q     <= '0;
            rbuf_q     <= '0;
            starve     <= '0;
            rw_q       <= 1'b0;
            ram_addr   <= '0;
            ram_data_o <= '0;
            if_done    <= 1'b0;
            ld_done    <= 1'b0;
            st_done    <= 1'b0;
            if_data    <= '0;
            ld_data    <= '0;
        end else if (rdy) begin
            if_done <= 1'b0;
            ld_done <= 1'b0;
            st_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        starve <= '0;
                    end else if ((grant_st || grant_ld) && if_req &&
                                 starve != SW'(STARVE_LIMIT)) begin
                        starve <= starve + 1'b1;
                    end
                    if (grant_st) begin
                        state      <= WRITE;
                        base_q     <= st_addr;
                        len_q      <= st_len;
                        cnt        <= '0;
                        rw_q       <= 1'b1;
                        ram_addr   <= st_addr;
                        ram_data_o <= st_data[7:0];
                        wbuf_q     <= {8'h00, st_data[31:8]};
                    end else if (grant_ld || grant_if) begin
                        state    <= READ;
                        owner_if <= grant_if;
                        base_q   <= grant_if ? if_addr : ld_addr;
                        len_q    <= grant_if ? 3'd4 : ld_len;
                        ram_addr <= grant_if ? if_addr : ld_addr;
                        cnt      <= '0;
                        rbuf_q   <= '0;
                    end
                end
                READ: begin
                    if (flush) begin
                        state    <= IDLE;
                        ram_addr <= '0;
                    end else begin
                        if (cnt != 3'd0) rbuf_q <= rbuf_nx;
                        if (cnt == len_q) begin
                            state    <= IDLE;
                            ram_addr <= '0;
                            if (owner_if) begin
                                if_done <= 1'b1;
                                if_data <= rbuf_nx;
                            end else begin
                                ld_done <= 1'b1;
                                ld_data <= rbuf_nx;
                            end
                        end else begin
                            cnt      <= nxt;
                            ram_addr <= base_q + {29'd0, off};
                        end
                    end
                end
                WRITE: begin
                    if (cnt == last) begin
                        state      <= IDLE;
                        rw_q       <= 1'b0;
                        ram_addr   <= '0;
                        ram_data_o <= '0;
                        st_done    <= 1'b1;
                    end else begin
                        cnt        <= nxt;
                        ram_addr   <= base_q + {29'd0, nxt};
                        ram_data_o <= wbuf_q[7:0];
                        wbuf_q     <= {8'h00, wbuf_q[31:8]};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed table plus hand sequences for ram_port_arbiter.
// The bench RAM shares the global ready, so it freezes together with the arbiter.
module tb_ram_port_arbiter;
    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic [7:0]  ram_data_i;
    logic [7:0]  ram_data_o;
    logic [31:0] ram_addr;
    logic        ram_rw_sel;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [2:0]  ld_len;
    logic        ld_done;
    logic [31:0] ld_data;
    logic        st_req;
    logic [31:0] st_addr;
    logic [2:0]  st_len;
    logic [31:0] st_data;
    logic        st_done;

    logic [7:0]  mem [0:65535];
    logic [31:0] trace_a [0:31];
    logic        trace_w [0:31];
    logic [2:0]  done_vec;
    int          n_chk;
    int          n_fail;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    assign done_vec = {if_done, ld_done, st_done};

    ram_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .flush      (flush),
        .ram_data_i (ram_data_i),
        .ram_data_o (ram_data_o),
        .ram_addr   (ram_addr),
        .ram_rw_sel (ram_rw_sel),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_data    (if_data),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_len     (ld_len),
        .ld_done    (ld_done),
        .ld_data    (ld_data),
        .st_req     (st_req),
        .st_addr    (st_addr),
        .st_len     (st_len),
        .st_data    (st_data),
        .st_done    (st_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM: registered read, write on strobe
    always @(posedge clk) begin
        if (rdy) begin
            if (ram_rw_sel) mem[ram_addr[15:0]] = ram_data_o;
            ram_data_i <= mem[ram_addr[15:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req_on(input int kind, input logic [31:0] a,
                          input logic [2:0] l, input logic [31:0] d);
        case (kind)
            0: begin if_req = 1'b1; if_addr = a; end
            1: begin ld_req = 1'b1; ld_addr = a; ld_len = l; end
            default: begin
                st_req = 1'b1; st_addr = a; st_len = l; st_data = d;
            end
        endcase
    endtask

    task automatic req_off(input int kind);
        case (kind)
            0: if_req = 1'b0;
            1: ld_req = 1'b0;
            default: st_req = 1'b0;
        endcase
    endtask

    function automatic logic [2:0] onehot(input int kind);
        case (kind)
            0: return 3'b100;
            1: return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input int n);
        logic [31:0] r;
        logic [31:0] ab;
        r = '0;
        for (int b = 0; b < n; b++) begin
            ab = a + 32'(b);
            r[8*b +: 8] = mem[ab[15:0]];
        end
        return r;
    endfunction

    // Steps until any done pulse, logging the port each cycle
    task automatic wait_done(input int max, output int lat);
        lat = -1;
        for (int c = 1; c <= max; c++) begin
            step();
            trace_a[c] = ram_addr;
            trace_w[c] = ram_rw_sel;
            if (done_vec != 3'b000) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int cnt;
        int errs;
        int n;
        logic [31:0] ea;

        n_chk = 0;
        n_fail = 0;
        rst = 1'b1; rdy = 1'b0; flush = 1'b0;
        if_req = 0; if_addr = '0;
        ld_req = 0; ld_addr = '0; ld_len = '0;
        st_req = 0; st_addr = '0; st_len = '0; st_data = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0100] = 8'h13; mem[16'h0101] = 8'h05;
        mem[16'h0040] = 8'hA1; mem[16'h0041] = 8'hB2;
        mem[16'h0042] = 8'hC3; mem[16'h0043] = 8'hD4;
        mem[16'hFFFE] = 8'h77; mem[16'hFFFF] = 8'h88;
        mem[16'h0000] = 8'h99; mem[16'h0001] = 8'hAA;
        mem[16'h0030] = 8'h11; mem[16'h0031] = 8'h22;

        vecs[0]  = '{0, 32'h0000_0100, 3'd4, 32'h0,         32'h0000_0513, 6};
        vecs[1]  = '{1, 32'h0000_0040, 3'd1, 32'h0,         32'h0000_00A1, 3};
        vecs[2]  = '{1, 32'h0000_0041, 3'd2, 32'h0,         32'h0000_C3B2, 4};
        vecs[3]  = '{1, 32'h0000_0040, 3'd4, 32'h0,         32'hD4C3_B2A1, 6};
        vecs[4]  = '{2, 32'h0000_0050, 3'd4, 32'h1234_5678, 32'h1234_5678, 5};
        vecs[5]  = '{1, 32'h0000_0050, 3'd4, 32'h0,         32'h1234_5678, 6};
        vecs[6]  = '{2, 32'h0000_0060, 3'd1, 32'hFFFF_FF5C, 32'h0000_005C, 2};
        vecs[7]  = '{1, 32'h0000_0060, 3'd2, 32'h0,         32'h0000_005C, 4};
        vecs[8]  = '{1, 32'hFFFF_FFFE, 3'd4, 32'h0,         32'hAA99_8877, 6};
        vecs[9]  = '{2, 32'hFFFF_FFFF, 3'd2, 32'h1234_CDAB, 32'h0000_CDAB, 3};
        vecs[10] = '{1, 32'hFFFF_FFFF, 3'd2, 32'h0,         32'h0000_CDAB, 4};

        // Reset applied while rdy is low
        repeat (3) step();
        chk("rst_addr", ram_addr, 32'h0);
        chk("rst_rw", {31'h0, ram_rw_sel}, 32'h0);
        chk("rst_wdata", {24'h0, ram_data_o}, 32'h0);
        chk("rst_done", {29'h0, done_vec}, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        rdy = 1'b1;
        step();
        rst = 1'b0;

        // Single-requester table
        for (int v = 0; v < NV; v++) begin
            n = (vecs[v].kind == 0) ? 4 : int'(vecs[v].len);
            req_on(vecs[v].kind, vecs[v].addr, vecs[v].len, vecs[v].wdata);
            wait_done(12, lat);
            req_off(vecs[v].kind);
            chk($sformatf("vec%0d_lat", v), lat, vecs[v].lat);
            chk($sformatf("vec%0d_who", v), {29'h0, done_vec},
                {29'h0, onehot(vecs[v].kind)});
            chk($sformatf("vec%0d_idle", v), ram_addr | {31'h0, ram_rw_sel}, 32'h0);
            case (vecs[v].kind)
                0: chk($sformatf("vec%0d_data", v), if_data, vecs[v].exp);
                1: chk($sformatf("vec%0d_data", v), ld_data, vecs[v].exp);
                default: chk($sformatf("vec%0d_mem", v),
                             mem_rd(vecs[v].addr, n), vecs[v].exp);
            endcase
            errs = 0;
            if (lat > 0) begin
                if (vecs[v].kind == 2) begin
                    for (int k = 0; k < n; k++) begin
                        ea = vecs[v].addr + 32'(k);
                        if (trace_a[k+1] !== ea || trace_w[k+1] !== 1'b1) errs++;
                    end
                end else begin
                    for (int k = 0; k <= n; k++) begin
                        ea = vecs[v].addr + 32'((k < n - 1) ? k : n - 1);
                        if (trace_a[k+1] !== ea || trace_w[k+1] !== 1'b0) errs++;
                    end
                end
            end
            chk($sformatf("vec%0d_trace", v), errs, 0);
            step();
        end

        // Contention: ST, then LD, then IF
        req_on(2, 32'h20, 3'd2, 32'h0000_BEEF);
        req_on(1, 32'h40, 3'd1, 32'h0);
        req_on(0, 32'h100, 3'd4, 32'h0);
        wait_done(12, lat);
        req_off(2);
        chk("cont_st_lat", lat, 3);
        chk("cont_st_who", {29'h0, done_vec}, 32'h1);
        wait_done(12, lat);
        req_off(1);
        chk("cont_ld_lat", lat, 4);
        chk("cont_ld_who", {29'h0, done_vec}, 32'h2);
        chk("cont_ld_data", ld_data, 32'h0000_00A1);
        wait_done(12, lat);
        req_off(0);
        chk("cont_if_lat", lat, 7);
        chk("cont_if_who", {29'h0, done_vec}, 32'h4);
        chk("cont_if_data", if_data, 32'h0000_0513);
        chk("cont_mem", mem_rd(32'h20, 2), 32'h0000_BEEF);
        step();

        // Starvation: IF forced in after two data-side grants
        req_on(0, 32'h100, 3'd4, 32'h0);
        req_on(1, 32'h40, 3'd1, 32'h0);
        req_on(2, 32'h70, 3'd1, 32'h3C);
        wait_done(12, lat);
        req_off(2);
        chk("starve_g1", {29'h0, done_vec}, 32'h1);
        wait_done(12, lat);
        req_on(2, 32'h74, 3'd1, 32'h5D);
        chk("starve_g2", {29'h0, done_vec}, 32'h2);
        wait_done(12, lat);
        req_off(0);
        chk("starve_if_lat", lat, 7);
        chk("starve_if_who", {29'h0, done_vec}, 32'h4);
        wait_done(12, lat);
        req_off(2);
        chk("starve_g4", {29'h0, done_vec}, 32'h1);
        wait_done(12, lat);
        req_off(1);
        chk("starve_g5", {29'h0, done_vec}, 32'h2);
        chk("starve_mem", {mem[16'h74], mem[16'h70]}, 32'h0000_5D3C);
        step();

        // Flush on the second READ cycle of a 4-byte load
        req_on(1, 32'h40, 3'd4, 32'h0);
        step();
        step();
        chk("flush_rd_addr", ram_addr, 32'h41);
        flush = 1'b1;
        ld_req = 1'b0;
        step();
        flush = 1'b0;
        chk("flush_rd_idle", ram_addr, 32'h0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (done_vec != 3'b000) cnt++;
            step();
        end
        chk("flush_rd_nodone", cnt, 0);
        chk("flush_rd_data", ld_data, 32'h0000_00A1);

        // Flush during a 4-byte store is ignored
        req_on(2, 32'h80, 3'd4, 32'hCAFE_F00D);
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            step();
            flush = (c == 2 || c == 3);
            if (st_done) begin
                lat = c;
                break;
            end
        end
        flush = 1'b0;
        req_off(2);
        chk("flush_st_lat", lat, 5);
        chk("flush_st_mem", mem_rd(32'h80, 4), 32'hCAFE_F00D);
        step();

        // rdy low for three cycles mid-load
        req_on(1, 32'h30, 3'd2, 32'h0);
        lat = -1;
        cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (ram_rw_sel) cnt++;
            if (ld_done) begin
                lat = c;
                break;
            end
            if (c == 2) rdy = 1'b0;
            if (c == 5) rdy = 1'b1;
        end
        rdy = 1'b1;
        req_off(1);
        chk("rdy_lat", lat, 7);
        chk("rdy_nowrite", cnt, 0);
        chk("rdy_data", ld_data, 32'h0000_2211);
        step();

        // Reset in the middle of a store
        req_on(2, 32'h90, 3'd4, 32'h4433_2211);
        step();
        step();
        rst = 1'b1;
        req_off(2);
        step();
        rst = 1'b0;
        chk("rstw_rw", {31'h0, ram_rw_sel}, 32'h0);
        chk("rstw_addr", ram_addr, 32'h0);
        chk("rstw_wdata", {24'h0, ram_data_o}, 32'h0);
        chk("rstw_ld_data", ld_data, 32'h0);
        chk("rstw_if_data", if_data, 32'h0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (done_vec != 3'b000) cnt++;
            step();
        end
        chk("rstw_nodone", cnt, 0);
        chk("rstw_mem", mem_rd(32'h90, 4), 32'h0000_2211);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
